vscale_htif_tohost_poller: RTL
==============================

# vscale_htif_tohost_poller

Host-side HTIF PCR master that replaces constant tie-offs on `vscale_sim_top`'s `htif_pcr_*` port in simulation harnesses. Repeatedly reads `CSR_ADDR_TO_HOST` with a full valid/ready handshake and decodes the first nonzero value into pass, fail-code or timeout status. Sits directly upstream of `vscale_sim_top`; status outputs go to the harness's `$finish` and reporting logic.

## Interface

- `POLL_GAP`, default 4: idle cycles between a zero response and the next read request (0 is legal).
- `CTR_W`, default 64: width of the cycle counter and of `max_cycles`.
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `max_cycles` input CTR_W: timeout limit; 0 disables the timeout.
- `htif_pcr_req_valid` output 1: request valid.
- `htif_pcr_req_ready` input 1: DUT accepts the request.
- `htif_pcr_req_rw` output 1: 0 = read, 1 = write.
- `htif_pcr_req_addr` output `HTIF_PCR_ADDR_WIDTH`: always `CSR_ADDR_TO_HOST`.
- `htif_pcr_req_data` output `HTIF_PCR_WIDTH`: write data; always 0.
- `htif_pcr_resp_valid` input 1: response valid.
- `htif_pcr_resp_ready` output 1: poller accepts the response.
- `htif_pcr_resp_data` input `HTIF_PCR_WIDTH`: read data.
- `done` output 1: sticky; the test has ended.
- `pass` output 1: sticky; tohost == 1.
- `timeout` output 1: sticky; the cycle limit was exceeded.
- `fail_code` output `HTIF_PCR_WIDTH`-1: tohost >> 1 when the test failed; 0 otherwise.
- `cycle_count` output CTR_W: cycles since reset was released.

## Operation

- FSM states:
  - IDLE → REQ on the first cycle after reset.
  - REQ: assert `req_valid`, `rw=0`. Go to RESP on `req_valid && req_ready`.
  - RESP: assert `resp_ready`. On `resp_valid`:
    - data == 0 → GAP.
    - data == 1 → set `pass`; go to CLR or DONE.
    - any other value → set `fail_code = data >> 1`; go to CLR or DONE.
  - GAP: count POLL_GAP cycles, then go to REQ. If POLL_GAP = 0, go directly to REQ.
  - CLR: see Configuration.
  - DONE: terminal. `done=1`; all request and response outputs are 0.
- `resp_data` is captured only in RESP with `resp_valid` high. Responses arriving in any other state are ignored, and `resp_ready` stays 0 in those states.
- Cycle counter:
  - Increments every cycle while `!reset && !done`.
  - Saturates at all-ones; no wrap.
- Timeout:
  - Condition: `max_cycles != 0 && cycle_count > max_cycles`.
  - Effect: set `timeout`, `done=1`, go to DONE from any state, dropping `req_valid` immediately. Any in-flight response is abandoned.
- Simultaneous events: a tohost decode in RESP and the timeout condition in the same cycle → the tohost result wins and `timeout` stays 0.
- `pass`, `timeout` and a nonzero `fail_code` are mutually exclusive.

## Timing

- Reset values: state IDLE; every output 0 except `htif_pcr_req_addr`, which is the constant `CSR_ADDR_TO_HOST`.
- Reset mid-operation: the FSM returns to IDLE on the next edge. Status and the counter clear. Any outstanding handshake is dropped with no completion.
- First `req_valid` appears on the 2nd cycle after reset deasserts.
- `req_valid`, `req_rw` and `req_data` are registered and held stable until `req_ready`. `req_valid` never deasserts without a handshake, except on timeout or reset.
- Minimum poll period with zero responses and single-cycle DUT responses: 2 + POLL_GAP cycles per read.
- `done`, `pass` and `fail_code` are registered: valid the cycle after the decisive `resp_valid`, or the cycle after CLR completes when the CLR state is used.
- `timeout` is asserted the cycle after `cycle_count` first exceeds `max_cycles`.

## Configuration

- `VSCALE_TOHOST_CLEAR_EN` defined: after a nonzero tohost, the CLR state issues one write (`rw=1`, `addr=CSR_ADDR_TO_HOST`, `data=0`). It waits for `req_ready`, then for one `resp_valid` (`resp_ready` high), then goes to DONE. Timeout still preempts CLR.
- Undefined: CLR is not compiled; nonzero tohost goes straight to DONE. `req_rw` is constant 0.

## Structure

- FSM state encodings and the pass value (1) are defined in `vscale_ctrl_constants.vh`.
- Address and width macros come from `vscale_csr_addr_map.vh` and `vscale_ctrl_constants.vh`.
- One sub-module, `vscale_cycle_timeout`: the saturating counter plus the max-cycles compare. Ports: `clk`, `reset`, `en`, `max_cycles`, `count`, `expired`.

## Test plan

- DUT model returns 0 three times, then 1; POLL_GAP=4; `req_ready`/`resp_valid` single-cycle.
  - Expect 4 read requests and `pass=1`, `done=1`, `fail_code=0`.
  - Spacing between requests: 6 cycles.
- Return 0x2A → `done=1`, `pass=0`, `fail_code=21`.
- `max_cycles=50`, DUT always returns 0 → `timeout=1` and `done=1` on the cycle after `cycle_count=51`. `req_valid` is low from then on.
- Hold `req_ready` low for 10 cycles → `req_valid`, `addr` and `rw` are stable throughout; exactly one request completes.
- Assert `reset` while in RESP, with `resp_valid` arriving on the same cycle as reset → response ignored; all outputs 0; polling restarts with a fresh counter.
- With `VSCALE_TOHOST_CLEAR_EN`, return 3 → a write with `rw=1`, `data=0` is observed; then `done=1` and `fail_code=1`.

Source files
------------

// File: rtl/vscale_htif_tohost_poller_pkg.sv
// Shared constants, FSM encoding and tohost decode for the HTIF tohost poller.
// Address/width values mirror the vscale CSR address map and control constants.
package vscale_htif_tohost_poller_pkg;

    localparam int HTIF_PCR_WIDTH      = 64;
    localparam int HTIF_PCR_ADDR_WIDTH = 12;

    localparam logic [HTIF_PCR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST = 12'h780;
    localparam logic [HTIF_PCR_WIDTH-1:0]      TOHOST_PASS      = 64'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_RESP     = 3'd2,
        ST_GAP      = 3'd3,
        ST_CLR_REQ  = 3'd4,
        ST_CLR_RESP = 3'd5,
        ST_DONE     = 3'd6
    } poller_state_e;

    typedef struct packed {
        logic                      pass;
        logic [HTIF_PCR_WIDTH-2:0] fail_code;
    } tohost_result_t;

    // Only called with a nonzero tohost value: 1 means pass, anything else is a fail code.
    function automatic tohost_result_t decode_tohost(input logic [HTIF_PCR_WIDTH-1:0] value);
        tohost_result_t res;
        res.pass      = (value == TOHOST_PASS);
        res.fail_code = res.pass ? '0 : value[HTIF_PCR_WIDTH-1:1];
        return res;
    endfunction

endpackage

// File: rtl/vscale_cycle_timeout.sv
// Saturating cycle counter with a max-cycles comparison; max_cycles == 0 never expires.
module vscale_cycle_timeout #(
    parameter int unsigned CTR_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CTR_W-1:0] max_cycles,
    output logic [CTR_W-1:0] count,
    output logic             expired
);

    logic [CTR_W-1:0] r_count;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + CTR_W'(1);
        end
    end

    assign count   = r_count;
    assign expired = (max_cycles != '0) && (r_count > max_cycles);

endmodule

// File: rtl/vscale_htif_tohost_poller.sv
// Host-side HTIF PCR master: polls tohost until nonzero, then reports pass/fail/timeout.
// Optional VSCALE_TOHOST_CLEAR_EN: write tohost back to 0 before reporting done.
module vscale_htif_tohost_poller
    import vscale_htif_tohost_poller_pkg::*;
#(
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned CTR_W    = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CTR_W-1:0]               max_cycles,
    output logic                           htif_pcr_req_valid,
    input  logic                           htif_pcr_req_ready,
    output logic                           htif_pcr_req_rw,
    output logic [HTIF_PCR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
    output logic [HTIF_PCR_WIDTH-1:0]      htif_pcr_req_data,
    input  logic                           htif_pcr_resp_valid,
    output logic                           htif_pcr_resp_ready,
    input  logic [HTIF_PCR_WIDTH-1:0]      htif_pcr_resp_data,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [HTIF_PCR_WIDTH-2:0]      fail_code,
    output logic [CTR_W-1:0]               cycle_count
);

    localparam int unsigned GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    poller_state_e             r_state;
    logic                      r_req_valid;
    logic                      r_resp_ready;
    logic [GAP_W-1:0]          r_gap_cnt;
    logic                      r_done;
    logic                      r_pass;
    logic                      r_timeout;
    logic [HTIF_PCR_WIDTH-2:0] r_fail_code;

    logic                      w_expired;
    logic                      w_decisive;
    tohost_result_t            w_resp_result;

    vscale_cycle_timeout #(.CTR_W(CTR_W)) u_cycle_timeout (
        .clk        (clk),
        .reset      (reset),
        .en         (!r_done),
        .max_cycles (max_cycles),
        .count      (cycle_count),
        .expired    (w_expired)
    );

    // A nonzero tohost arriving in RESP beats a simultaneous timeout.
    assign w_decisive    = (r_state == ST_RESP) && htif_pcr_resp_valid && (htif_pcr_resp_data != '0);
    assign w_resp_result = decode_tohost(htif_pcr_resp_data);

`ifdef VSCALE_TOHOST_CLEAR_EN
    logic                      r_req_rw;
    logic [HTIF_PCR_WIDTH-1:0] r_tohost;
    tohost_result_t            w_clr_result;

    assign w_clr_result    = decode_tohost(r_tohost);
    assign htif_pcr_req_rw = r_req_rw;
`else
    assign htif_pcr_req_rw = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_gap_cnt    <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_fail_code  <= '0;
`ifdef VSCALE_TOHOST_CLEAR_EN
            r_req_rw     <= 1'b0;
            r_tohost     <= '0;
`endif
        end else if (w_expired && !w_decisive && (r_state != ST_DONE)) begin
            r_state      <= ST_DONE;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_done       <= 1'b1;
            r_timeout    <= 1'b1;
`ifdef VSCALE_TOHOST_CLEAR_EN
            r_req_rw     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_REQ;
                    r_req_valid <= 1'b1;
                end
                ST_REQ: begin
                    if (htif_pcr_req_ready) begin
                        r_state      <= ST_RESP;
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (htif_pcr_resp_valid) begin
                        r_resp_ready <= 1'b0;
                        if (htif_pcr_resp_data == '0) begin
                            if (POLL_GAP == 0) begin
                                r_state     <= ST_REQ;
                                r_req_valid <= 1'b1;
                            end else begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= '0;
                            end
                        end else begin
`ifdef VSCALE_TOHOST_CLEAR_EN
                            r_state     <= ST_CLR_REQ;
                            r_tohost    <= htif_pcr_resp_data;
                            r_req_valid <= 1'b1;
                            r_req_rw    <= 1'b1;
`else
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_pass      <= w_resp_result.pass;
                            r_fail_code <= w_resp_result.fail_code;
`endif
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST[GAP_W-1:0]) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
`ifdef VSCALE_TOHOST_CLEAR_EN
                ST_CLR_REQ: begin
                    if (htif_pcr_req_ready) begin
                        r_state      <= ST_CLR_RESP;
                        r_req_valid  <= 1'b0;
                        r_req_rw     <= 1'b0;
                        r_resp_ready <= 1'b1;
                    end
                end
                ST_CLR_RESP: begin
                    if (htif_pcr_resp_valid) begin
                        r_state      <= ST_DONE;
                        r_resp_ready <= 1'b0;
                        r_done       <= 1'b1;
                        r_pass       <= w_clr_result.pass;
                        r_fail_code  <= w_clr_result.fail_code;
                    end
                end
`endif
                default: begin
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

    assign htif_pcr_req_valid  = r_req_valid;
    assign htif_pcr_req_addr   = CSR_ADDR_TO_HOST;
    assign htif_pcr_req_data   = '0;
    assign htif_pcr_resp_ready = r_resp_ready;
    assign done                = r_done;
    assign pass                = r_pass;
    assign timeout             = r_timeout;
    assign fail_code           = r_fail_code;

endmodule
